// File: rtl/rr_grant_scheduler8_pkg.sv
// rr_grant_scheduler8_pkg: shared state codes and widths for the round-robin grant scheduler
package rr_grant_scheduler8_pkg;
  localparam int N_REQ = 8;
  localparam int ID_W = 3;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_e;
endpackage

// File: rtl/rr_grant_scheduler8_if.sv
// rr_grant_scheduler8_if: request/grant bundle between requesters (master) and scheduler (slave)
interface rr_grant_scheduler8_if;
  import rr_grant_scheduler8_pkg::*;
  logic en;
  logic [N_REQ-1:0] req;
  logic rel;
  logic [N_REQ-1:0] gnt;
  logic gnt_valid;
  logic [ID_W-1:0] gnt_id;
  logic gnt_new;
  modport master (output en, req, rel, input gnt, gnt_valid, gnt_id, gnt_new);
  modport slave (input en, req, rel, output gnt, gnt_valid, gnt_id, gnt_new);
endinterface

// File: rtl/rr_grant_scheduler8_decoder.sv
// onehot_decoder3x8: enabled 3-to-8 one-hot decoder producing the grant vector
module onehot_decoder3x8
  import rr_grant_scheduler8_pkg::*;
(
  input  logic en_i,
  input  logic [ID_W-1:0] sel_i,
  output logic [N_REQ-1:0] y_o
);
  assign y_o = en_i ? N_REQ'(1) << sel_i : '0;
endmodule

// File: rtl/rr_grant_scheduler8.sv
// rr_grant_scheduler8: round-robin arbiter for 8 requesters with a bounded hold quantum
module rr_grant_scheduler8
  import rr_grant_scheduler8_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input logic clk,
  input logic reset,
  rr_grant_scheduler8_if.slave bus
);
  localparam int HW = HOLD_MAX > 1 ? $clog2(HOLD_MAX) : 1;
  state_e state_q, state_d;
  logic [ID_W-1:0] id_q, id_d, ptr_q, ptr_d, pick;
  logic [HW-1:0] hold_q, hold_d;
  logic new_q, new_d;
  logic [N_REQ-1:0] gnt, rot;
  logic expired, others, keep, any;
  onehot_decoder3x8 u_dec (.en_i(state_q == ST_GRANT), .sel_i(id_q), .y_o(gnt));
  // rotate so ptr sits at bit 0; the lowest set bit is the next owner
  always_comb begin
    rot = N_REQ'({bus.req, bus.req} >> ptr_q);
    pick = ptr_q;
    for (int i = N_REQ - 1; i >= 0; i--) pick = rot[i] ? ptr_q + ID_W'(i) : pick;
  end
  assign any = bus.en & |bus.req;
  assign expired = hold_q == HW'(HOLD_MAX - 1);
  assign others = |(bus.req & ~gnt);
  assign keep = (state_q == ST_GRANT) & bus.en & bus.req[id_q] & ~bus.rel & ~(expired & others);
  always_comb begin
    new_d = ~keep & any;
    state_d = (keep | any) ? ST_GRANT : ST_IDLE;
    id_d = new_d ? pick : keep ? id_q : '0;
    ptr_d = new_d ? pick + ID_W'(1) : ptr_q;
    hold_d = new_d ? '0 : (keep & ~expired) ? hold_q + HW'(1) : hold_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      id_q <= '0;
      ptr_q <= '0;
      hold_q <= '0;
      new_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      ptr_q <= ptr_d;
      hold_q <= hold_d;
      new_q <= new_d;
    end
  end
  assign bus.gnt = gnt;
  assign bus.gnt_valid = state_q == ST_GRANT;
  assign bus.gnt_id = id_q;
  assign bus.gnt_new = new_q;
endmodule

// File: tb/tb_rr_grant_scheduler8.sv
// tb_rr_grant_scheduler8: scenario tasks feeding a stimulus/expectation scoreboard
module tb_rr_grant_scheduler8;
  typedef struct packed {
    logic en;
    logic [7:0] req;
    logic rel;
    logic [12:0] exp;
  } ent_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cmp = 0;
  int mism = 0;
  ent_t sb[$];
  ent_t e;
  logic [12:0] obs;
  rr_grant_scheduler8_if b ();
  rr_grant_scheduler8 #(.HOLD_MAX(4)) dut (.clk(clk), .reset(reset), .bus(b));
  always #5 clk = ~clk;
  assign obs = {b.gnt_valid, b.gnt_new, b.gnt_id, b.gnt};
  function automatic ent_t mk(logic en, logic [7:0] req, logic rel, logic v, logic nw, int id);
    ent_t t;
    logic [7:0] g;
    g = v ? 8'(1 << id) : 8'h00;
    t.en = en;
    t.req = req;
    t.rel = rel;
    t.exp = {v, nw, 3'(id), g};
    return t;
  endfunction
  task automatic pulse_reset();
    @(negedge clk);
    b.en = 1'b0;
    b.req = '0;
    b.rel = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
  endtask
  task automatic test_reset();
    b.en = 1'b0;
    b.req = '0;
    b.rel = 1'b0;
    #3;
    cmp++;
    if (obs !== 13'h0) begin mism++; $display("FAIL reset_init got %h want %h", obs, 13'h0); end
    @(negedge clk) reset = 1'b0;
    sb.push_back(mk(1, 8'h04, 0, 1, 1, 2));
    sb.push_back(mk(1, 8'h04, 0, 1, 0, 2));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      {b.en, b.req, b.rel} = {e.en, e.req, e.rel};
      @(posedge clk); #1;
      cmp++;
      if (obs !== e.exp) begin mism++; $display("FAIL reset_pre got %h want %h", obs, e.exp); end
    end
    #2 reset = 1'b1;
    #1;
    cmp++;
    if (obs !== 13'h0) begin mism++; $display("FAIL reset_mid got %h want %h", obs, 13'h0); end
    #1 reset = 1'b0;
    sb.push_back(mk(1, 8'h01, 0, 1, 1, 0));
    sb.push_back(mk(1, 8'h01, 0, 1, 0, 0));
    sb.push_back(mk(0, 8'h00, 0, 0, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      {b.en, b.req, b.rel} = {e.en, e.req, e.rel};
      @(posedge clk); #1;
      cmp++;
      if (obs !== e.exp) begin mism++; $display("FAIL reset_post got %h want %h", obs, e.exp); end
    end
  endtask
  task automatic test_single();
    sb.push_back(mk(1, 8'h04, 0, 1, 1, 2));
    sb.push_back(mk(1, 8'h04, 0, 1, 0, 2));
    sb.push_back(mk(1, 8'h00, 0, 0, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      {b.en, b.req, b.rel} = {e.en, e.req, e.rel};
      @(posedge clk); #1;
      cmp++;
      if (obs !== e.exp) begin mism++; $display("FAIL single got %h want %h", obs, e.exp); end
    end
  endtask
  task automatic test_rotation();
    pulse_reset();
    for (int k = 0; k < 9; k++)
      for (int c = 0; c < 4; c++) sb.push_back(mk(1, 8'hFF, 0, 1, c == 0, k % 8));
    sb.push_back(mk(1, 8'h00, 0, 0, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      {b.en, b.req, b.rel} = {e.en, e.req, e.rel};
      @(posedge clk); #1;
      cmp++;
      if (obs !== e.exp) begin mism++; $display("FAIL rotation got %h want %h", obs, e.exp); end
    end
  endtask
  task automatic test_release();
    pulse_reset();
    sb.push_back(mk(1, 8'h11, 0, 1, 1, 0));
    sb.push_back(mk(1, 8'h11, 1, 1, 1, 4));
    sb.push_back(mk(1, 8'h11, 0, 1, 0, 4));
    sb.push_back(mk(1, 8'h00, 0, 0, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      {b.en, b.req, b.rel} = {e.en, e.req, e.rel};
      @(posedge clk); #1;
      cmp++;
      if (obs !== e.exp) begin mism++; $display("FAIL release got %h want %h", obs, e.exp); end
    end
  endtask
  task automatic test_sole();
    sb.push_back(mk(1, 8'h20, 0, 1, 1, 5));
    for (int c = 1; c < 20; c++) sb.push_back(mk(1, 8'h20, 0, 1, 0, 5));
    sb.push_back(mk(1, 8'h20, 1, 1, 1, 5));
    sb.push_back(mk(1, 8'h20, 0, 1, 0, 5));
    sb.push_back(mk(1, 8'h00, 0, 0, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      {b.en, b.req, b.rel} = {e.en, e.req, e.rel};
      @(posedge clk); #1;
      cmp++;
      if (obs !== e.exp) begin mism++; $display("FAIL sole got %h want %h", obs, e.exp); end
    end
  endtask
  task automatic test_back_to_back();
    sb.push_back(mk(1, 8'h08, 0, 1, 1, 3));
    sb.push_back(mk(1, 8'h08, 0, 1, 0, 3));
    sb.push_back(mk(0, 8'h08, 0, 0, 0, 0));
    sb.push_back(mk(0, 8'h08, 0, 0, 0, 0));
    sb.push_back(mk(1, 8'h09, 0, 1, 1, 0));
    for (int c = 1; c < 4; c++) sb.push_back(mk(1, 8'h09, 0, 1, 0, 0));
    sb.push_back(mk(1, 8'h09, 0, 1, 1, 3));
    sb.push_back(mk(1, 8'h00, 0, 0, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      {b.en, b.req, b.rel} = {e.en, e.req, e.rel};
      @(posedge clk); #1;
      cmp++;
      if (obs !== e.exp) begin mism++; $display("FAIL enable got %h want %h", obs, e.exp); end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_release();
    test_sole();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end
endmodule
